// File: rtl/definitions_pkg.sv
// Shared types and constants for the memory responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package definitions;

    // Width of the wait-state counter; WAIT_CYCLES must fit in it.
    localparam int MEM_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read; written to map onto block RAM.
// Latency: read data appears the cycle after re_i; writes land on the same edge as we_i.
// Backpressure: none; accepts an access every cycle, read output holds until the next re_i.
module mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage and read register; no reset so the array stays block-RAM friendly.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder behind the MAR/MDR interface; optional MEM_RANGE_CHECK_EN flags out-of-range accesses.
// Latency: request sampled at T, mem_resp pulses at T+1+WAIT_CYCLES with registered rdata.
// Backpressure: mem_busy high from T+1 through the response cycle; strobes seen while busy are dropped.
module mem_responder
    import definitions::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              memR_En,
    input  logic              memW_En,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_resp,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t            state_q, state_d;
    logic [MEM_WAIT_W-1:0] cnt_q, cnt_d;
    mem_op_t               op_q, op_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  oor_q, oor_d;
    logic                  rd_zero_q;

    logic                  req;
    mem_op_t               req_op;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_oor;
    logic                  enter_resp;
    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_W-1:0]     arr_rdata;

    // Byte-lane bits never select anything; upper bits only matter with the range check.
    logic                  addr_unused;
    assign addr_unused = ^{addr[1:0], addr[ADDR_W-1:IDX_W+2]};

    assign req     = memR_En | memW_En;
    assign req_op  = memW_En ? WRITE : READ;
    assign req_idx = addr[IDX_W+1:2];

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor = (addr >> (IDX_W + 2)) != '0;
`else
    assign req_oor = 1'b0;
`endif

    // Next-state and request-latch logic; array access is decided on the transition into RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        oor_d      = oor_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d    = req_op;
                    idx_d   = req_idx;
                    wdata_d = wdata;
                    oor_d   = req_oor;
                    cnt_d   = MEM_WAIT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == MEM_WAIT_W'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The _d values carry the live request when WAIT_CYCLES is 0 and the latched one otherwise.
    // Reset wins over the access so an abandoned write never reaches the array.
    assign arr_we = enter_resp & ~Reset & (op_d == WRITE) & ~oor_d;
    assign arr_re = enter_resp & ~Reset & (op_d == READ)  & ~oor_d;

    // FSM, request latches and the read-data zero flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= READ;
            idx_q     <= '0;
            wdata_q   <= '0;
            oor_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            if (enter_resp && (op_d == READ)) begin
                rd_zero_q <= oor_d;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .idx_i   (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (arr_rdata)
    );

    // The array output register has no reset, so rdata is forced to 0 after reset and for out-of-range reads.
    assign rdata    = rd_zero_q ? '0 : arr_rdata;
    assign mem_resp = (state_q == RESP);
    assign mem_busy = (state_q != IDLE);

`ifdef MEM_RANGE_CHECK_EN
    assign mem_err = (state_q == RESP) & oor_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (1 and 0 wait states), directed then random traffic.
// Latency: expected response cycle is computed per request from the wait-state count.
// Backpressure: the model drops requests issued before the responder is free again.
module tb_mem_responder;

    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic        r0 = 1'b0, w0 = 1'b0, resp0, busy0, err0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        r1 = 1'b0, w1 = 1'b0, resp1, busy1, err1;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
        .Clk(Clk), .Reset(Reset), .addr(addr0), .wdata(wdata0), .memR_En(r0), .memW_En(w0),
        .rdata(rdata0), .mem_resp(resp0), .mem_busy(busy0), .mem_err(err0));

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u1 (
        .Clk(Clk), .Reset(Reset), .addr(addr1), .wdata(wdata1), .memR_En(r1), .memW_En(w1),
        .rdata(rdata1), .mem_resp(resp1), .mem_busy(busy1), .mem_err(err1));

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [31:0] m0[int], m1[int];
    int          next_ok[2], blo[2], bhi[2];
    logic [31:0] last_rd[2];

    function automatic int wc(int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic bit is_oor(logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a >= 32'(DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    // Word slot after wrapping modulo the array size.
    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mread(int d, int i);
        if (d == 0) return m0.exists(i) ? m0[i] : 32'h0;
        return m1.exists(i) ? m1[i] : 32'h0;
    endfunction

    task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s d%0d cyc=%0d: got %h expected %h", nm, d, cyc, act, exp);
        end
    endtask

    // Called at a negedge; presents a request for one cycle. track=0 means the access will be abandoned by reset.
    task automatic drive(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd, bit track);
        exp_t e;
        if (d == 0) begin r0 = rd; w0 = wr; addr0 = a; wdata0 = wd; end
        else        begin r1 = rd; w1 = wr; addr1 = a; wdata1 = wd; end
        if ((rd || wr) && cyc >= next_ok[d]) begin
            e.cyc = cyc + 1 + wc(d);
            e.err = is_oor(a);
            if (wr) begin
                if (!e.err && track) begin
                    if (d == 0) m0[widx(a)] = wd; else m1[widx(a)] = wd;
                end
                e.rdata = last_rd[d];
            end else begin
                e.rdata = e.err ? 32'h0 : mread(d, widx(a));
                last_rd[d] = e.rdata;
            end
            if (track) begin
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            next_ok[d] = cyc + 2 + wc(d);
            blo[d] = cyc + 1;
            bhi[d] = cyc + 1 + wc(d);
        end
        @(negedge Clk);
        if (d == 0) begin r0 = 1'b0; w0 = 1'b0; end
        else        begin r1 = 1'b0; w1 = 1'b0; end
    endtask

    task automatic wait_free(int d);
        while (cyc < next_ok[d]) @(negedge Clk);
    endtask

    task automatic check_zero_outputs();
        check("rst_rdata", 0, rdata0, 32'h0);
        check("rst_resp", 0, 32'(resp0), 32'h0);
        check("rst_busy", 0, 32'(busy0), 32'h0);
        check("rst_err", 0, 32'(err0), 32'h0);
        check("rst_rdata", 1, rdata1, 32'h0);
        check("rst_resp", 1, 32'(resp1), 32'h0);
        check("rst_busy", 1, 32'(busy1), 32'h0);
        check("rst_err", 1, 32'(err1), 32'h0);
    endtask

    // One-cycle reset from a negedge; outputs are checked at the following negedge.
    task automatic do_reset();
        Reset = 1'b1;
        for (int d = 0; d < 2; d++) if (bhi[d] > cyc) bhi[d] = cyc;
        @(negedge Clk);
        check_zero_outputs();
        Reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 32'h0;
            next_ok[d] = cyc;
            blo[d] = 1;
            bhi[d] = 0;
        end
    endtask

    task automatic mon(int d);
        logic        resp, busy, err;
        logic [31:0] rd;
        exp_t        e;
        int          qs;
        resp = (d == 0) ? resp0 : resp1;
        busy = (d == 0) ? busy0 : busy1;
        err  = (d == 0) ? err0  : err1;
        rd   = (d == 0) ? rdata0 : rdata1;
        check("busy", d, 32'(busy), 32'((cyc >= blo[d]) && (cyc <= bhi[d])));
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.cyc < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL missing_resp d%0d: got none expected resp at cyc %0d", d, e.cyc);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                qs--;
            end
        end
        if (resp) begin
            if (qs == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_resp d%0d cyc=%0d: got resp expected none", d, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check("resp_cyc", d, 32'(cyc), 32'(e.cyc));
                check("rdata", d, rd, e.rdata);
                check("err", d, 32'(err), 32'(e.err));
            end
        end else begin
            check("err_idle", d, 32'(err), 32'h0);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        int t;
        bit rd, wr;
        logic [31:0] a;
        int d;

        for (int i = 0; i < 2; i++) begin
            next_ok[i] = 0; blo[i] = 1; bhi[i] = 0; last_rd[i] = 32'h0;
        end
        repeat (3) @(negedge Clk);
        check_zero_outputs();
        Reset = 1'b0;
        next_ok[0] = cyc; next_ok[1] = cyc;
        chk_en = 1'b1;

        // Basic write then read with one wait state.
        drive(1, 0, 1, 32'h10, 32'hDEADBEEF, 1); wait_free(1);
        drive(1, 1, 0, 32'h10, 32'h0, 1);        wait_free(1);

        // Zero wait states: read, dropped strobe at T+1, accepted read at T+2.
        drive(0, 0, 1, 32'h0, 32'h11110000, 1);  wait_free(0);
        drive(0, 0, 1, 32'h4, 32'h22220000, 1);  wait_free(0);
        drive(0, 1, 0, 32'h0, 32'h0, 1);
        drive(0, 1, 0, 32'h4, 32'h0, 1);
        drive(0, 1, 0, 32'h4, 32'h0, 1);         wait_free(0);

        // Both strobes act as a write and leave rdata alone.
        drive(1, 1, 1, 32'h20, 32'h12345678, 1); wait_free(1);
        drive(1, 1, 0, 32'h22, 32'h0, 1);        wait_free(1);

        // Strobe during WAIT is dropped.
        drive(1, 0, 1, 32'h30, 32'h0000AAAA, 1); wait_free(1);
        drive(1, 0, 1, 32'h50, 32'h00005050, 1);
        drive(1, 0, 1, 32'h30, 32'h00000005, 1); wait_free(1);
        drive(1, 1, 0, 32'h30, 32'h0, 1);        wait_free(1);

        // Reset in WAIT abandons the write.
        drive(1, 0, 1, 32'h40, 32'h00004444, 1); wait_free(1);
        drive(1, 1, 0, 32'h10, 32'h0, 1);        wait_free(1);
        wait_free(0);
        drive(1, 0, 1, 32'h40, 32'h00009999, 0);
        do_reset();
        drive(1, 1, 0, 32'h40, 32'h0, 1);        wait_free(1);

        // Address one array-size above 0x8: error or alias depending on the build.
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 1, 32'h8, 32'h08080808, 1);            wait_free(k);
            drive(k, 0, 1, 32'(DEPTH * 4 + 8), 32'hCAFEF00D, 1); wait_free(k);
            drive(k, 1, 0, 32'(DEPTH * 4 + 8), 32'h0, 1);      wait_free(k);
            drive(k, 1, 0, 32'h8, 32'h0, 1);                   wait_free(k);
        end

        // Seed a small address pool on both instances, then random traffic over it.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) begin
                drive(k, 0, 1, 32'(w * 4), $urandom, 1); wait_free(k);
            end
        end
        for (int i = 0; i < 400; i++) begin
            d  = int'($urandom_range(1, 0));
            t  = int'($urandom_range(2, 0));
            rd = (t != 1);
            wr = (t != 0);
            a  = 32'($urandom_range(15, 0) * 4 + $urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) a = a + 32'(DEPTH * 4 * $urandom_range(3, 1));
            drive(d, rd, wr, a, $urandom, 1);
            repeat ($urandom_range(2, 0)) @(negedge Clk);
        end

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge Clk);
            t++;
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
